// File: rtl/node_position_streamer.sv
// node_position_streamer
//
// Producer-side front end of the center-of-mass path. A start pulse sweeps
// the node-position RAM once (addresses 0..NUM_NODES-1) and streams one
// x/y sample per node to the center-of-mass accumulator. It then pulses
// tabulate_out to make the accumulator divide, waits for its result,
// latches it and reports completion with done_out. Each start is one
// self-contained transaction.
//
// Optional feature: define NODE_MASK_EN to add node_mask_in. Bit i = 1
// suppresses node i's sample. The mask is captured on an accepted start
// and held for the whole transaction. Masked slots leave a valid_out gap.
// Sweep timing is unchanged.
//
// Ports:
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   start_in                start pulse, accepted only while idle
//   busy_out                high whenever a transaction is in progress
//   rd_en_out, addr_out     RAM read port (data returns RAM_LATENCY later)
//   x_data_in, y_data_in    RAM read data
//   x_out, y_out, valid_out node sample stream to the accumulator
//   tabulate_out            one-cycle divide trigger to the accumulator
//   com_x_in, com_y_in,
//   com_valid_in            accumulator result and its strobe
//   com_x_out, com_y_out    latched accumulator result
//   done_out                one-cycle completion pulse
//   error_out               sticky error (zero samples or result timeout),
//                           cleared by an accepted start
//   node_mask_in            per-node suppress mask (NODE_MASK_EN only)
module node_position_streamer #(
  parameter int POSITION_SIZE  = 8,
  parameter int NUM_NODES      = 16,
  parameter int RAM_LATENCY    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int AW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     start_in,
  output logic                     busy_out,
  output logic                     rd_en_out,
  output logic [AW-1:0]            addr_out,
  input  logic [POSITION_SIZE-1:0] x_data_in,
  input  logic [POSITION_SIZE-1:0] y_data_in,
  output logic [POSITION_SIZE-1:0] x_out,
  output logic [POSITION_SIZE-1:0] y_out,
  output logic                     valid_out,
  output logic                     tabulate_out,
  input  logic [POSITION_SIZE-1:0] com_x_in,
  input  logic [POSITION_SIZE-1:0] com_y_in,
  input  logic                     com_valid_in,
  output logic [POSITION_SIZE-1:0] com_x_out,
  output logic [POSITION_SIZE-1:0] com_y_out,
  output logic                     done_out,
`ifdef NODE_MASK_EN
  input  logic [NUM_NODES-1:0]     node_mask_in,
`endif
  output logic                     error_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_TABULATE,
    S_WAIT_COM,
    S_COOLDOWN,
    S_FINISH
  } state_t;

  state_t state, state_nx;

  // Control strobes decoded from the current state
  logic accept;      // start taken in IDLE
  logic fetch_last;  // last address of the sweep is being issued
  logic err_set;     // zero-sample or timeout error this cycle
  logic com_take;    // accumulator result captured this cycle

  logic [AW:0]               cnt;      // emitted samples
  logic [TW-1:0]             tmo_cnt;  // cycles spent in WAIT_COM
  logic [RAM_LATENCY-1:0]    vld_p;    // masked read strobe, tap feeds output
  logic [RAM_LATENCY:0]      raw_p;    // unmasked read strobe incl. output slot
  logic                      slot_masked;

`ifdef NODE_MASK_EN
  logic [NUM_NODES-1:0] mask_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mask_q <= '0;
    end else if (accept) begin
      mask_q <= node_mask_in;
    end
  end

  assign slot_masked = mask_q[addr_out];
`else
  assign slot_masked = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nx     = state;
    accept       = 1'b0;
    fetch_last   = 1'b0;
    err_set      = 1'b0;
    com_take     = 1'b0;
    busy_out     = 1'b1;
    tabulate_out = 1'b0;
    done_out     = 1'b0;
    case (state)
      S_IDLE: begin
        busy_out = 1'b0;
        if (start_in) begin
          accept   = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        if (addr_out == AW'(NUM_NODES - 1)) begin
          fetch_last = 1'b1;
          state_nx   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Once no read is left ahead of the output register, any sample in
        // the output register is the last one. A nonzero total (counting a
        // sample still on valid_out) can tabulate right away; a zero total
        // is only final after the last output slot, masked or not, retires.
        if (~|raw_p[RAM_LATENCY-1:0]) begin
          if ((cnt != '0) || valid_out) begin
            state_nx = S_TABULATE;
          end else if (!raw_p[RAM_LATENCY]) begin
            // Tabulating with zero mass would stall the accumulator.
            err_set  = 1'b1;
            state_nx = S_FINISH;
          end
        end
      end
      S_TABULATE: begin
        tabulate_out = 1'b1;
        state_nx     = S_WAIT_COM;
      end
      S_WAIT_COM: begin
        if (com_valid_in) begin
          com_take = 1'b1;
          state_nx = S_COOLDOWN;
        end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          err_set  = 1'b1;
          state_nx = S_COOLDOWN;
        end
      end
      S_COOLDOWN: begin
        // Covers the accumulator's one-cycle internal clear.
        state_nx = S_FINISH;
      end
      S_FINISH: begin
        done_out = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Read address generation
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_en_out <= 1'b0;
      addr_out  <= '0;
    end else if (accept) begin
      rd_en_out <= 1'b1;
      addr_out  <= '0;
    end else if (fetch_last) begin
      rd_en_out <= 1'b0;
      addr_out  <= '0;
    end else if (rd_en_out) begin
      addr_out  <= addr_out + AW'(1);
    end
  end

  // Stage p0..pL-1: read strobe travels alongside the RAM latency
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_p <= '0;
      raw_p <= '0;
    end else begin
      vld_p[0] <= rd_en_out & ~slot_masked;
      raw_p[0] <= rd_en_out;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
      for (int i = 1; i <= RAM_LATENCY; i++) begin
        raw_p[i] <= raw_p[i-1];
      end
    end
  end

  // Output stage: capture RAM data on the delayed strobe
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x_out     <= '0;
      y_out     <= '0;
      valid_out <= 1'b0;
    end else if (vld_p[RAM_LATENCY-1]) begin
      x_out     <= x_data_in;
      y_out     <= y_data_in;
      valid_out <= 1'b1;
    end else begin
      valid_out <= 1'b0;
    end
  end

  // Emitted-sample counter
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (valid_out) begin
      cnt <= cnt + (AW+1)'(1);
    end
  end

  // Result timeout counter, zero on every entry to WAIT_COM
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tmo_cnt <= '0;
    end else if (state == S_WAIT_COM) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Result latch and sticky error
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      com_x_out <= '0;
      com_y_out <= '0;
      error_out <= 1'b0;
    end else begin
      if (com_take) begin
        com_x_out <= com_x_in;
        com_y_out <= com_y_in;
      end
      if (accept) begin
        error_out <= 1'b0;
      end else if (err_set) begin
        error_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_node_position_streamer.sv
module tb_node_position_streamer;

  localparam int PS = 8;
  localparam int N  = 4;
  localparam int L  = 2;
  localparam int T  = 16;
  localparam int AW = $clog2(N);

  logic          clk_in;
  logic          rst_n_in;
  logic          start_in;
  logic          busy_out;
  logic          rd_en_out;
  logic [AW-1:0] addr_out;
  logic [PS-1:0] x_data_in, y_data_in;
  logic [PS-1:0] x_out, y_out;
  logic          valid_out;
  logic          tabulate_out;
  logic [PS-1:0] com_x_in, com_y_in;
  logic          com_valid_in;
  logic [PS-1:0] com_x_out, com_y_out;
  logic          done_out;
  logic          error_out;
`ifdef NODE_MASK_EN
  logic [N-1:0]  node_mask;
`endif

  node_position_streamer #(
    .POSITION_SIZE (PS),
    .NUM_NODES     (N),
    .RAM_LATENCY   (L),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .start_in     (start_in),
    .busy_out     (busy_out),
    .rd_en_out    (rd_en_out),
    .addr_out     (addr_out),
    .x_data_in    (x_data_in),
    .y_data_in    (y_data_in),
    .x_out        (x_out),
    .y_out        (y_out),
    .valid_out    (valid_out),
    .tabulate_out (tabulate_out),
    .com_x_in     (com_x_in),
    .com_y_in     (com_y_in),
    .com_valid_in (com_valid_in),
    .com_x_out    (com_x_out),
    .com_y_out    (com_y_out),
    .done_out     (done_out),
`ifdef NODE_MASK_EN
    .node_mask_in (node_mask),
`endif
    .error_out    (error_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // RAM model: data for a read appears L cycles after rd_en, garbage otherwise
  logic [PS-1:0] mem_x [N];
  logic [PS-1:0] mem_y [N];
  logic [PS-1:0] rx_p [L];
  logic [PS-1:0] ry_p [L];

  always @(posedge clk_in) begin
    rx_p[0] <= rd_en_out ? mem_x[addr_out] : PS'($urandom);
    ry_p[0] <= rd_en_out ? mem_y[addr_out] : PS'($urandom);
    for (int i = 1; i < L; i++) begin
      rx_p[i] <= rx_p[i-1];
      ry_p[i] <= ry_p[i-1];
    end
  end
  assign x_data_in = rx_p[L-1];
  assign y_data_in = ry_p[L-1];

  // Event recorder (absolute cycle numbers)
  typedef struct {
    int c;
    int x;
    int y;
  } samp_t;
  samp_t sq[$];
  int    tabq[$];
  int    doneq[$];
  int    rdc[$];
  int    rda[$];

  always @(negedge clk_in) begin
    samp_t s;
    if (rst_n_in) begin
      if (valid_out) begin
        s.c = cyc;
        s.x = int'(x_out);
        s.y = int'(y_out);
        sq.push_back(s);
      end
      if (tabulate_out) tabq.push_back(cyc);
      if (done_out) doneq.push_back(cyc);
      if (rd_en_out) begin
        rdc.push_back(cyc);
        rda.push_back(int'(addr_out));
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int base  = 0;
  logic [PS-1:0] exp_cx = '0;
  logic [PS-1:0] exp_cy = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < N; i++) begin
      mem_x[i] = PS'($urandom);
      mem_y[i] = PS'($urandom);
    end
  endtask

  task automatic clear_log();
    sq.delete();
    tabq.delete();
    doneq.delete();
    rdc.delete();
    rda.delete();
  endtask

  // One full transaction. com_rel < 0 means the accumulator never answers.
  // inject adds ignored starts (FETCH and done cycle) and stray com_valid
  // pulses outside WAIT_COM.
  task automatic run_txn(input logic [N-1:0] mask, input int com_rel,
                         input logic [PS-1:0] cx, input logic [PS-1:0] cy,
                         input bit inject);
    int    nem;
    int    tab_exp;
    int    done_exp;
    bit    err_exp;
    int    k;
    samp_t s;

    // Reference model from the timing rules
    nem = 0;
    for (int i = 0; i < N; i++) if (!mask[i]) nem++;
    tab_exp = N + L + 2;
    if (nem == 0) begin
      done_exp = N + L + 3;
      err_exp  = 1'b1;
    end else if (com_rel >= 0) begin
      done_exp = com_rel + 2;
      err_exp  = 1'b0;
    end else begin
      done_exp = N + L + T + 4;
      err_exp  = 1'b1;
    end

    clear_log();
    @(negedge clk_in);
    start_in = 1'b1;
`ifdef NODE_MASK_EN
    node_mask = mask;
`endif
    base = cyc;
    for (int r = 1; r <= done_exp + 1; r++) begin
      @(negedge clk_in);
      start_in     = 1'b0;
      com_valid_in = 1'b0;
      chk($sformatf("busy_c%0d", r), {63'd0, busy_out}, {63'd0, r <= done_exp});
      if (r == 1) chk("error_cleared_on_start", {63'd0, error_out}, 64'd0);
      if (inject && r == 2) start_in = 1'b1;
      if (inject && r == done_exp) start_in = 1'b1;
      if (inject && (r == 3 || (nem > 0 && r == tab_exp))) begin
        com_valid_in = 1'b1;
        com_x_in     = PS'($urandom);
        com_y_in     = PS'($urandom);
      end
      if (r == com_rel && nem > 0) begin
        com_valid_in = 1'b1;
        com_x_in     = cx;
        com_y_in     = cy;
      end
    end
    start_in     = 1'b0;
    com_valid_in = 1'b0;

    if (nem > 0 && com_rel >= 0) begin
      exp_cx = cx;
      exp_cy = cy;
    end

    // Reads: addresses 0..N-1 in cycles 1..N
    chk("rd_count", 64'(rdc.size()), 64'(N));
    for (int i = 0; i < N && i < rdc.size(); i++) begin
      chk($sformatf("rd%0d_cycle", i), 64'(rdc[i] - base), 64'(i + 1));
      chk($sformatf("rd%0d_addr", i), 64'(rda[i]), 64'(i));
    end

    // Samples: node i in cycle i+L+2 unless masked
    chk("sample_count", 64'(sq.size()), 64'(nem));
    k = 0;
    for (int i = 0; i < N; i++) begin
      if (!mask[i]) begin
        if (k < sq.size()) begin
          s = sq[k];
          chk($sformatf("s%0d_cycle", i), 64'(s.c - base), 64'(i + L + 2));
          chk($sformatf("s%0d_x", i), 64'(s.x), 64'(mem_x[i]));
          chk($sformatf("s%0d_y", i), 64'(s.y), 64'(mem_y[i]));
        end
        k++;
      end
    end

    chk("tabulate_count", 64'(tabq.size()), 64'(nem > 0 ? 1 : 0));
    if (nem > 0 && tabq.size() > 0) chk("tabulate_cycle", 64'(tabq[0] - base), 64'(tab_exp));
    chk("done_count", 64'(doneq.size()), 64'd1);
    if (doneq.size() > 0) chk("done_cycle", 64'(doneq[0] - base), 64'(done_exp));
    chk("error_after", {63'd0, error_out}, {63'd0, err_exp});
    chk("com_x_out", 64'(com_x_out), 64'(exp_cx));
    chk("com_y_out", 64'(com_y_out), 64'(exp_cy));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, {63'd0, busy_out}, 64'd0);
    chk({tag, "_rd_en"}, {63'd0, rd_en_out}, 64'd0);
    chk({tag, "_addr"}, 64'(addr_out), 64'd0);
    chk({tag, "_x"}, 64'(x_out), 64'd0);
    chk({tag, "_y"}, 64'(y_out), 64'd0);
    chk({tag, "_valid"}, {63'd0, valid_out}, 64'd0);
    chk({tag, "_tab"}, {63'd0, tabulate_out}, 64'd0);
    chk({tag, "_comx"}, 64'(com_x_out), 64'd0);
    chk({tag, "_comy"}, 64'(com_y_out), 64'd0);
    chk({tag, "_done"}, {63'd0, done_out}, 64'd0);
    chk({tag, "_error"}, {63'd0, error_out}, 64'd0);
  endtask

  initial begin
    int cr;
    rst_n_in     = 1'b0;
    start_in     = 1'b0;
    com_valid_in = 1'b0;
    com_x_in     = '0;
    com_y_in     = '0;
`ifdef NODE_MASK_EN
    node_mask    = '0;
`endif
    repeat (3) @(negedge clk_in);
    check_all_zero("reset");
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // Directed sweep with the reference RAM contents and a (25,5) result
    mem_x[0] = 8'd10; mem_x[1] = 8'd20; mem_x[2] = 8'd30; mem_x[3] = 8'd40;
    mem_y[0] = 8'd2;  mem_y[1] = 8'd4;  mem_y[2] = 8'd6;  mem_y[3] = 8'd8;
    run_txn('0, 15, 8'd25, 8'd5, 1'b0);

    // No result: timeout, latched result kept, stray starts/com ignored
    randomize_mem();
    run_txn('0, -1, '0, '0, 1'b1);

    // Result on the first and on the last WAIT_COM cycle
    randomize_mem();
    run_txn('0, N + L + 3, PS'($urandom), PS'($urandom), 1'b1);
    randomize_mem();
    run_txn('0, N + L + 2 + T, PS'($urandom), PS'($urandom), 1'b0);

    // Random transactions
    for (int t = 0; t < 4; t++) begin
      randomize_mem();
      cr = $urandom_range(N + L + 2 + T, N + L + 3);
      run_txn('0, cr, PS'($urandom), PS'($urandom), 1'($urandom));
    end

    // Reset asserted in DRAIN aborts the transaction
    randomize_mem();
    clear_log();
    @(negedge clk_in);
    start_in = 1'b1;
    base = cyc;
    @(negedge clk_in);
    start_in = 1'b0;
    while (cyc - base < N + 2) @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_cx = '0;
    exp_cy = '0;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    clear_log();
    repeat (N + L + T + 10) @(negedge clk_in);
    chk("post_reset_tab", 64'(tabq.size()), 64'd0);
    chk("post_reset_done", 64'(doneq.size()), 64'd0);
    chk("post_reset_busy", {63'd0, busy_out}, 64'd0);
    randomize_mem();
    run_txn('0, N + L + 6, PS'($urandom), PS'($urandom), 1'b0);

`ifdef NODE_MASK_EN
    randomize_mem();
    run_txn(4'b0101, N + L + 5, PS'($urandom), PS'($urandom), 1'b0);
    randomize_mem();
    run_txn(4'b1111, N + L + 5, PS'($urandom), PS'($urandom), 1'b1);
    for (int t = 0; t < 3; t++) begin
      randomize_mem();
      cr = $urandom_range(N + L + 2 + T, N + L + 3);
      run_txn(N'($urandom), cr, PS'($urandom), PS'($urandom), 1'($urandom));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
